// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
// Handshake and data bundle between the execute stage and the sequential ALU.
//
// Signals:
//   in_valid   master->slave  operands and op valid this cycle
//   in_ready   slave->master  ALU can accept an op
//   opA, opB   master->slave  operands, XLEN bits
//   aluOutSel  master->slave  5-bit operation select
//   out_valid  slave->master  aluOut holds a completed result
//   out_ready  master->slave  consumer takes the result this cycle
//   aluOut     slave->master  registered result, XLEN bits
//   busy       slave->master  multiply/divide iteration in progress
// ---------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic [4:0]      aluOutSel;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] aluOut;
    logic            busy;

    // The execute stage drives operands and takes results
    modport master (
        output in_valid, opA, opB, aluOutSel, out_ready,
        input  in_ready, out_valid, aluOut, busy
    );

    // The ALU consumes operands and produces results
    modport slave (
        input  in_valid, opA, opB, aluOutSel, out_ready,
        output in_ready, out_valid, aluOut, busy
    );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Multi-cycle RV32I/RV32M ALU. Base ops and divide special cases finish one
// cycle after acceptance; multiply/divide iterate one bit per cycle and finish
// XLEN+1 cycles after acceptance. Results are held until out_ready.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, aborts any op in flight
//   bus    alu_seq_if slave modport (valid/ready in, valid/ready out)
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [SHW-1:0]      cnt_q, cnt_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     operand_q, operand_d;
    logic [4:0]          op_q, op_d;
    logic                negA_q, negA_d;
    logic                negB_q, negB_d;
    logic [XLEN-1:0]     aluOut_q, aluOut_d;

    logic [SHW-1:0]      shamt;
    logic [XLEN-1:0]     baseRes;
    logic                isMul, isDiv, signA, signB, divZero, divOvf;
    logic [XLEN-1:0]     magA, magB, specialRes;
    logic [XLEN:0]       mulSum, divShift, divDiff;
    logic [2*XLEN-1:0]   stepProd, fullProd;
    logic [XLEN-1:0]     quot, rem, iterRes;

    // Single-cycle base ALU; reserved selects fall through to zero.
    always_comb begin
        shamt   = bus.opB[SHW-1:0];
        baseRes = '0;
        case (bus.aluOutSel)
            OP_ADD:  baseRes = bus.opA + bus.opB;
            OP_SUB:  baseRes = bus.opA - bus.opB;
            OP_SLL:  baseRes = bus.opA << shamt;
            OP_SLT:  baseRes = {{(XLEN-1){1'b0}}, $signed(bus.opA) < $signed(bus.opB)};
            OP_SLTU: baseRes = {{(XLEN-1){1'b0}}, bus.opA < bus.opB};
            OP_XOR:  baseRes = bus.opA ^ bus.opB;
            OP_SRL:  baseRes = bus.opA >> shamt;
            OP_SRA:  baseRes = $signed(bus.opA) >>> shamt;
            OP_OR:   baseRes = bus.opA | bus.opB;
            OP_AND:  baseRes = bus.opA & bus.opB;
            default: baseRes = '0;
        endcase
    end

    // Operand decode at accept: the iterative core works on magnitudes, so
    // signed variants record the operand signs for the final correction.
    // Divide-by-zero and signed overflow bypass iteration entirely.
    always_comb begin
        isMul   = (bus.aluOutSel >= OP_MUL) && (bus.aluOutSel <= OP_MULHU);
        isDiv   = (bus.aluOutSel >= OP_DIV) && (bus.aluOutSel <= OP_REMU);
        signA   = ((bus.aluOutSel == OP_MULH) || (bus.aluOutSel == OP_MULHSU) ||
                   (bus.aluOutSel == OP_DIV)  || (bus.aluOutSel == OP_REM)) && bus.opA[XLEN-1];
        signB   = ((bus.aluOutSel == OP_MULH) || (bus.aluOutSel == OP_DIV) ||
                   (bus.aluOutSel == OP_REM)) && bus.opB[XLEN-1];
        magA    = signA ? -bus.opA : bus.opA;
        magB    = signB ? -bus.opB : bus.opB;
        divZero = (bus.opB == '0);
        divOvf  = ((bus.aluOutSel == OP_DIV) || (bus.aluOutSel == OP_REM)) &&
                  (bus.opA == MOST_NEG) && (bus.opB == '1);
        if (divZero) begin
            specialRes = ((bus.aluOutSel == OP_DIV) || (bus.aluOutSel == OP_DIVU)) ? '1 : bus.opA;
        end else begin
            specialRes = (bus.aluOutSel == OP_DIV) ? bus.opA : '0;
        end
    end

    // One iteration step. Multiply: add-and-shift-right on {hi, multiplier}.
    // Divide: prod holds {remainder, dividend/quotient}; shift left, trial
    // subtract, and shift the quotient bit in at the bottom.
    always_comb begin
        mulSum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, operand_q} : '0);
        divShift = prod_q[2*XLEN-1:XLEN-1];
        divDiff  = divShift - {1'b0, operand_q};
        if (op_q <= OP_MULHU) begin
            stepProd = {mulSum, prod_q[XLEN-1:1]};
        end else if (!divDiff[XLEN]) begin
            stepProd = {divDiff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        end else begin
            stepProd = {divShift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
        end

        fullProd = (negA_q ^ negB_q) ? -stepProd : stepProd;
        quot     = stepProd[XLEN-1:0];
        rem      = stepProd[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       iterRes = fullProd[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: iterRes = fullProd[2*XLEN-1:XLEN];
            OP_DIV:                       iterRes = (negA_q ^ negB_q) ? -quot : quot;
            OP_DIVU:                      iterRes = quot;
            OP_REM:                       iterRes = negA_q ? -rem : rem;
            default:                      iterRes = rem;
        endcase
    end

    // Next-state and datapath load control for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        operand_d = operand_q;
        op_d      = op_q;
        negA_d    = negA_q;
        negB_d    = negB_q;
        aluOut_d  = aluOut_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d   = bus.aluOutSel;
                    negA_d = signA;
                    negB_d = signB;
                    cnt_d  = '0;
                    if (isMul) begin
                        prod_d    = {{XLEN{1'b0}}, magB};
                        operand_d = magA;
                        state_d   = BUSY;
                    end else if (isDiv && !divZero && !divOvf) begin
                        prod_d    = {{XLEN{1'b0}}, magA};
                        operand_d = magB;
                        state_d   = BUSY;
                    end else begin
                        aluOut_d = isDiv ? specialRes : baseRes;
                        state_d  = DONE;
                    end
                end
            end
            BUSY: begin
                prod_d = stepProd;
                cnt_d  = cnt_q + SHW'(1);
                if (cnt_q == SHW'(XLEN-1)) begin
                    aluOut_d = iterRes;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prod_q    <= '0;
            operand_q <= '0;
            op_q      <= '0;
            negA_q    <= 1'b0;
            negB_q    <= 1'b0;
            aluOut_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            operand_q <= operand_d;
            op_q      <= op_d;
            negA_q    <= negA_d;
            negB_q    <= negB_d;
            aluOut_q  <= aluOut_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == BUSY);
    assign bus.aluOut    = aluOut_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq: directed ops, div special cases,
// backpressure, mid-op reset abort, then randomized ops against a
// behavioural reference model built from wide integer arithmetic.
// ---------------------------------------------------------------------------
module tb_alu_seq;
    localparam int XLEN = 32;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;

    alu_seq_if #(.XLEN(XLEN)) bus ();

    alu_seq #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop so a wedged DUT can never hang the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Every comparison funnels through here so counts stay honest
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: results straight from the RISC-V definitions using
    // 64-bit integer arithmetic rather than any iterative scheme
    function automatic logic [31:0] refAlu(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return {31'b0, $signed(a) < $signed(b)};
            5'd4:  return {31'b0, a < b};
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  return $signed(a) >>> b[4:0];
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: begin p = ua * ub; return p[31:0]; end
            5'd11: begin p = sa * sb; return p[63:32]; end
            5'd12: begin p = sa * ub; return p[63:32]; end
            5'd13: begin p = ua * ub; return p[63:32]; end
            5'd14: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (ovf) return a;
                return $signed(a) / $signed(b);
            end
            5'd15: return (b == 0) ? 32'hFFFFFFFF : a / b;
            5'd16: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            5'd17: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    // Latency from the definition: iterative ops take XLEN+1, all else 1
    function automatic int refLatency(input logic [4:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        if (op >= 5'd10 && op <= 5'd13) return XLEN + 1;
        if (op >= 5'd14 && op <= 5'd17) begin
            if (b == 0) return 1;
            if ((op == 5'd14 || op == 5'd16) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
            return XLEN + 1;
        end
        return 1;
    endfunction

    // Operands biased towards boundary values
    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    // One full transaction with out_ready held high; called one time unit
    // after a rising edge with the DUT idle. Operands are scrambled right
    // after acceptance to show they are captured only at the accept edge.
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        int          cycles;
        int          busyCycles;
        int          expLat;
        logic [31:0] expRes;
        string       tag;
        expRes = refAlu(op, a, b);
        expLat = refLatency(op, a, b);
        tag    = $sformatf("op%0d(%0h,%0h)", op, a, b);
        bus.aluOutSel = op;
        bus.opA       = a;
        bus.opB       = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.opA       = $urandom();
        bus.opB       = $urandom();
        bus.aluOutSel = 5'($urandom_range(0, 31));
        cycles     = 1;
        busyCycles = 0;
        while (!bus.out_valid && cycles < 200) begin
            busyCycles += int'(bus.busy);
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({tag, " latency"}, 64'(cycles), 64'(expLat));
        checkOutput({tag, " result"}, 64'(bus.aluOut), 64'(expRes));
        checkOutput({tag, " busyCycles"}, 64'(busyCycles), 64'(expLat - 1));
        @(posedge clk);
        #1;
        checkOutput({tag, " drained"}, 64'(bus.out_valid), 64'(0));
    endtask

    initial begin
        int          cycles;
        int          errs;
        int          seen;
        logic [31:0] held;

        // Reset asserted mid-cycle while an op is being offered
        rst_n         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.aluOutSel = 5'd0;
        bus.opA       = 32'd5;
        bus.opB       = 32'd1;
        bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstOutValid", 64'(bus.out_valid), 64'(0));
        checkOutput("rstAluOut", 64'(bus.aluOut), 64'(0));
        checkOutput("rstBusy", 64'(bus.busy), 64'(0));
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstInReady", 64'(bus.in_ready), 64'(1));
        checkOutput("rstNoAccept", 64'(bus.out_valid), 64'(0));

        // Base ops
        applyStimulus(5'd0, 32'd5, 32'd1);
        applyStimulus(5'd1, 32'd7, 32'd4);
        applyStimulus(5'd2, 32'd1, 32'd0);
        applyStimulus(5'd3, 32'd1, 32'd1);
        applyStimulus(5'd5, 32'd38, 32'd33);
        applyStimulus(5'd7, 32'h80000000, 32'd4);

        // Multiply
        applyStimulus(5'd10, 32'hFFFFFFFF, 32'd2);
        applyStimulus(5'd11, 32'hFFFFFFFD, 32'd4);
        applyStimulus(5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF);

        // Divide
        applyStimulus(5'd14, 32'hFFFFFFF9, 32'd2);
        applyStimulus(5'd16, 32'hFFFFFFF9, 32'd2);
        applyStimulus(5'd15, 32'd100, 32'd7);
        applyStimulus(5'd17, 32'd100, 32'd7);

        // Divide special cases
        applyStimulus(5'd14, 32'd5, 32'd0);
        applyStimulus(5'd17, 32'd5, 32'd0);
        applyStimulus(5'd14, 32'h80000000, 32'hFFFFFFFF);
        applyStimulus(5'd16, 32'h80000000, 32'hFFFFFFFF);

        // Backpressure: result must sit still while the upstream stage
        // keeps pushing, and the handshake edge must not also accept
        bus.aluOutSel = 5'd15;
        bus.opA       = 32'd1000;
        bus.opB       = 32'd7;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cycles = 1;
        while (!bus.out_valid && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("bpLatency", 64'(cycles), 64'(XLEN + 1));
        held = bus.aluOut;
        checkOutput("bpResult", 64'(held), 64'(142));
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid  = (i % 2 == 1);
            bus.opA       = $urandom();
            bus.aluOutSel = 5'd0;
            @(posedge clk);
            #1;
            if (bus.aluOut !== held || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) errs++;
        end
        checkOutput("bpStable", 64'(errs), 64'(0));
        bus.in_valid  = 1'b1;
        bus.aluOutSel = 5'd0;
        bus.opA       = 32'd20;
        bus.opB       = 32'd22;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bpIdleAfterHandshake", 64'(bus.in_ready), 64'(1));
        checkOutput("bpNoSameCycleAccept", 64'(bus.out_valid), 64'(0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("bpNextValid", 64'(bus.out_valid), 64'(1));
        checkOutput("bpNextResult", 64'(bus.aluOut), 64'(42));
        @(posedge clk);
        #1;

        // Abort: reset pulsed in the 16th busy cycle of a multiply
        bus.aluOutSel = 5'd10;
        bus.opA       = $urandom();
        bus.opB       = $urandom();
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("abortBusyBefore", 64'(bus.busy), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abortBusy", 64'(bus.busy), 64'(0));
        checkOutput("abortAluOut", 64'(bus.aluOut), 64'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            seen += int'(bus.out_valid);
        end
        checkOutput("abortNoResult", 64'(seen), 64'(0));
        checkOutput("abortInReady", 64'(bus.in_ready), 64'(1));

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            applyStimulus(5'($urandom_range(0, 22)), pickOperand(), pickOperand());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
